// File: rtl/trig_buffer_pkg.sv
// trig_buffer_pkg: shared constants and types for the trigger stream buffer.
// Optional statistics counters are enabled by defining TRIG_BUFFER_STATS_EN.
package trig_buffer_pkg;

    localparam int DEPTH_DEF      = 16;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int HOLDOFF_DEF    = 16;

    localparam int ACC_CNT_W  = 32;
    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        NONE,
        RUNRST,
        HOLDOFF,
        OVERFLOW
    } drop_cause_e;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(
        input logic [DROP_CNT_W-1:0] v
    );
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/trig_buffer_fifo.sv
// trig_buffer_fifo: word storage with pointers, level and a first-word
// fall-through output register; level includes the output register.
module trig_buffer_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [LVL_W-1:0]      level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic             pop;
    logic             load;
    logic [LVL_W-1:0] ram_cnt;

    // Words still in RAM are those not yet moved into the output register.
    assign pop     = valid_q & ready_i;
    assign ram_cnt = level_q - LVL_W'(valid_q);
    assign load    = (ram_cnt != '0) & (~valid_q | pop);

    // Storage write; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Next-state for pointers, level and the output register.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        valid_d  = valid_q;
        data_d   = data_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            valid_d  = 1'b0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (load) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                valid_d  = 1'b1;
                data_d   = mem_q[rd_ptr_q];
            end else if (pop) begin
                valid_d = 1'b0;
            end
            unique case ({push_i, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign rdata_o = data_q;
    assign valid_o = valid_q;
    assign level_o = level_q;

endmodule

// File: rtl/trig_stream_buffer.sv
// trig_stream_buffer: never-stalling trigger intake with holdoff gate,
// elastic buffer and drop statistics (define TRIG_BUFFER_STATS_EN).
module trig_stream_buffer
    import trig_buffer_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int HOLDOFF_BITS = HOLDOFF_DEF,
    parameter int LVL_W        = $clog2(DEPTH) + 1
) (
    input  logic                    ifclk,
    input  logic                    aresetn,
    input  logic [DATA_WIDTH-1:0]   s_trig_tdata,
    input  logic                    s_trig_tvalid,
    output logic                    s_trig_tready,
    output logic [DATA_WIDTH-1:0]   m_trig_tdata,
    output logic                    m_trig_tvalid,
    input  logic                    m_trig_tready,
    input  logic [HOLDOFF_BITS-1:0] holdoff_i,
    input  logic                    runrst_i,
    output logic [LVL_W-1:0]        level_o,
    output logic [ACC_CNT_W-1:0]    accept_cnt_o,
    output logic [DROP_CNT_W-1:0]   ovf_drop_o,
    output logic [DROP_CNT_W-1:0]   hold_drop_o
);

    logic                    ready_q;
    logic [HOLDOFF_BITS-1:0] hold_q, hold_d;
    logic [LVL_W-1:0]        level;
    logic                    beat;
    logic                    full;
    logic                    push;
    drop_cause_e             cause;

    assign beat = s_trig_tvalid & ready_q;
    assign full = (level == LVL_W'(DEPTH));

    // Classify each beat by drop priority; NONE on a beat means write.
    always_comb begin
        cause = NONE;
        if (beat) begin
            priority case (1'b1)
                runrst_i:         cause = RUNRST;
                (hold_q != '0):   cause = HOLDOFF;
                full:             cause = OVERFLOW;
                default:          cause = NONE;
            endcase
        end
    end

    assign push = beat & (cause == NONE);

    // Holdoff counter reloads on each accepted word, else counts down.
    always_comb begin
        hold_d = hold_q;
        if (runrst_i) begin
            hold_d = '0;
        end else if (push) begin
            hold_d = holdoff_i;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLDOFF_BITS'(1);
        end
    end

    // Ready rises on the first edge after reset and stays high.
    always_ff @(posedge ifclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            ready_q <= 1'b1;
            hold_q  <= hold_d;
        end
    end

    trig_buffer_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .LVL_W      (LVL_W)
    ) u_fifo (
        .clk_i   (ifclk),
        .rst_ni  (aresetn),
        .flush_i (runrst_i),
        .push_i  (push),
        .wdata_i (s_trig_tdata),
        .rdata_o (m_trig_tdata),
        .valid_o (m_trig_tvalid),
        .ready_i (m_trig_tready),
        .level_o (level)
    );

    assign s_trig_tready = ready_q;
    assign level_o       = level;

`ifdef TRIG_BUFFER_STATS_EN
    logic [ACC_CNT_W-1:0]  acc_q, acc_d;
    logic [DROP_CNT_W-1:0] ovf_q, ovf_d;
    logic [DROP_CNT_W-1:0] hd_q, hd_d;

    // Accept counter wraps; drop counters saturate.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        hd_d  = hd_q;
        if (runrst_i) begin
            acc_d = '0;
            ovf_d = '0;
            hd_d  = '0;
        end else if (beat) begin
            unique case (cause)
                NONE:     acc_d = acc_q + ACC_CNT_W'(1);
                HOLDOFF:  hd_d  = sat_inc(hd_q);
                OVERFLOW: ovf_d = sat_inc(ovf_q);
                default:  acc_d = acc_q;
            endcase
        end
    end

    // Statistics registers.
    always_ff @(posedge ifclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q <= '0;
            ovf_q <= '0;
            hd_q  <= '0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            hd_q  <= hd_d;
        end
    end

    assign accept_cnt_o = acc_q;
    assign ovf_drop_o   = ovf_q;
    assign hold_drop_o  = hd_q;
`else
    assign accept_cnt_o = '0;
    assign ovf_drop_o   = '0;
    assign hold_drop_o  = '0;
`endif

endmodule

// File: tb/tb_trig_stream_buffer.sv
// tb_trig_stream_buffer: randomized and directed stimulus against a
// queue-based reference model of the trigger stream buffer.
module tb_trig_stream_buffer;

    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int HB    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef TRIG_BUFFER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          aresetn = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [HB-1:0] holdoff = '0;
    logic          runrst = 1'b0;
    logic [LW-1:0] level;
    logic [31:0]   acc_cnt;
    logic [15:0]   ovf_cnt;
    logic [15:0]   hd_cnt;

    always #5 clk = ~clk;

    trig_stream_buffer #(
        .DEPTH        (DEPTH),
        .DATA_WIDTH   (DW),
        .HOLDOFF_BITS (HB)
    ) dut (
        .ifclk         (clk),
        .aresetn       (aresetn),
        .s_trig_tdata  (s_tdata),
        .s_trig_tvalid (s_tvalid),
        .s_trig_tready (s_tready),
        .m_trig_tdata  (m_tdata),
        .m_trig_tvalid (m_tvalid),
        .m_trig_tready (m_tready),
        .holdoff_i     (holdoff),
        .runrst_i      (runrst),
        .level_o       (level),
        .accept_cnt_o  (acc_cnt),
        .ovf_drop_o    (ovf_cnt),
        .hold_drop_o   (hd_cnt)
    );

    typedef struct {
        logic [DW-1:0] d;
        longint        ts;
    } ent_t;

    ent_t        q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    longint      ecnt = 0;
    longint      next_ok = 0;
    int unsigned m_acc = 0;
    int          m_ovf = 0;
    int          m_hd = 0;
    bit          m_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at edge %0d",
                     tag, got, exp, ecnt);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_acc   = 0;
        m_ovf   = 0;
        m_hd    = 0;
        next_ok = 0;
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d,
                         input bit rdy, input bit rr);
        s_tvalid = v;
        s_tdata  = d;
        m_tready = rdy;
        runrst   = rr;
    endtask

    // Check pre-edge outputs, advance the model across one edge.
    task automatic cycle();
        bit ev;
        bit full;
        ev = (q.size() > 0) && (q[0].ts + 2 <= ecnt);
        chk("tready", 64'(s_tready), 64'(m_rdy));
        chk("tvalid", 64'(m_tvalid), 64'(ev));
        if (ev) chk("tdata", 64'(m_tdata), 64'(q[0].d));
        chk("level", 64'(level), 64'(q.size()));
        chk("acc", 64'(acc_cnt), STATS ? 64'(m_acc) : 64'(0));
        chk("ovf", 64'(ovf_cnt), STATS ? 64'(m_ovf) : 64'(0));
        chk("hold", 64'(hd_cnt), STATS ? 64'(m_hd) : 64'(0));
        if (runrst) begin
            model_clear();
        end else begin
            full = (q.size() == DEPTH);
            if (ev && m_tready) void'(q.pop_front());
            if (s_tvalid && m_rdy) begin
                if (ecnt < next_ok) begin
                    if (m_hd < 65535) m_hd++;
                end else if (full) begin
                    if (m_ovf < 65535) m_ovf++;
                end else begin
                    q.push_back('{d: s_tdata, ts: ecnt});
                    m_acc++;
                    next_ok = ecnt + longint'(holdoff) + 1;
                end
            end
        end
        m_rdy = 1'b1;
        @(posedge clk);
        ecnt++;
        @(negedge clk);
    endtask

    task automatic rst_check(input string tag);
        chk({tag, "_tready"}, 64'(s_tready), 64'(0));
        chk({tag, "_tvalid"}, 64'(m_tvalid), 64'(0));
        chk({tag, "_tdata"}, 64'(m_tdata), 64'(0));
        chk({tag, "_level"}, 64'(level), 64'(0));
        chk({tag, "_acc"}, 64'(acc_cnt), 64'(0));
        chk({tag, "_ovf"}, 64'(ovf_cnt), 64'(0));
        chk({tag, "_hold"}, 64'(hd_cnt), 64'(0));
    endtask

    task automatic do_reset(input string tag);
        #2 aresetn = 1'b0;
        #1 rst_check(tag);
        model_clear();
        m_rdy = 1'b0;
        repeat (2) begin
            @(posedge clk);
            ecnt++;
            @(negedge clk);
        end
        rst_check({tag, "_held"});
        drive(0, '0, 0, 0);
        aresetn = 1'b1;
        cycle();
    endtask

    task automatic flush();
        drive(0, '0, 0, 1);
        cycle();
        drive(0, '0, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        do_reset("rst");
        cycle();

        // Back-to-back words with a ready sink.
        holdoff = '0;
        for (int i = 0; i < 20; i++) begin
            drive(1, DW'(i), 1, 0);
            cycle();
        end
        drive(0, '0, 1, 0);
        repeat (4) cycle();
        chk("b2b_acc", 64'(acc_cnt), STATS ? 64'(20) : 64'(0));

        // Fill a stalled buffer past capacity, then drain.
        flush();
        for (int i = 0; i < 20; i++) begin
            drive(1, DW'(i), 0, 0);
            cycle();
        end
        drive(0, '0, 0, 0);
        chk("full_level", 64'(level), 64'(DEPTH));
        chk("full_ovf", 64'(ovf_cnt), STATS ? 64'(4) : 64'(0));
        drive(0, '0, 1, 0);
        repeat (20) cycle();

        // Holdoff of 10 with a word offered every cycle.
        flush();
        holdoff = HB'(10);
        for (int i = 0; i < 30; i++) begin
            drive(1, DW'(32'h100 + i), 1, 0);
            cycle();
        end
        drive(0, '0, 1, 0);
        chk("hold_drops", 64'(hd_cnt), STATS ? 64'(27) : 64'(0));
        holdoff = '0;
        repeat (4) cycle();

        // Flush mid-handshake with five words held.
        flush();
        for (int i = 0; i < 5; i++) begin
            drive(1, DW'(32'h200 + i), 0, 0);
            cycle();
        end
        drive(0, '0, 0, 0);
        cycle();
        flush();
        drive(1, DW'(32'hABCD), 1, 0);
        cycle();
        drive(0, '0, 1, 0);
        repeat (3) cycle();

        // Asynchronous reset in the middle of streaming.
        for (int i = 0; i < 6; i++) begin
            drive(1, DW'(32'h300 + i), 0, 0);
            cycle();
        end
        do_reset("arst");
        drive(1, DW'(32'h4444), 1, 0);
        cycle();
        drive(0, '0, 1, 0);
        repeat (3) cycle();

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) holdoff = HB'($urandom_range(0, 3));
            drive(($urandom % 4) != 0, DW'($urandom),
                  ($urandom % 3) != 0, ($urandom % 97) == 0);
            cycle();
        end

        // Overflow counter saturation.
        flush();
        holdoff = '0;
        for (int i = 0; i < DEPTH + 65540; i++) begin
            drive(1, DW'(i), 0, 0);
            cycle();
        end
        drive(0, '0, 0, 0);
        chk("ovf_sat", 64'(ovf_cnt), STATS ? 64'(16'hFFFF) : 64'(0));
        chk("sat_acc", 64'(acc_cnt), STATS ? 64'(DEPTH) : 64'(0));
        chk("sat_hold", 64'(hd_cnt), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
